apple_bus_responder: RTL
========================

# apple_bus_responder

Drives the Apple II data bus when the card answers a 6502 read in its slot space: the transmit direction of the bus interface. Takes the latched address, R/W and phase strobes from the bus receiver, decodes DEVSEL, IOSEL and (optionally) IOSTROBE for the configured slot, and fetches the response byte from card logic over a request/acknowledge handshake. Drives the byte with a timed output enable inside Phi0 and releases the bus shortly after Phi0 falls.

## Interface
Parameters:
- SLOT, 4: slot number 1–7; sets DEVSEL $C080+16·SLOT and IOSEL page $Cn00.
- DRIVE_START_COUNT, 8: clk_logic cycles after phi0_posedge at which a2_d_oe_o asserts; also the ack deadline.
- HOLD_COUNT, 2: cycles a2_d_oe_o stays high after phi0_negedge.

Ports:
- clk_logic_i  in  1  logic clock, 54 MHz; the only clock.
- system_reset_i  in  1  reset, synchronous, active-high.
- timing_lock_i  in  1  bus timing recovered; no drive while low.
- phi0_posedge_i  in  1  one-cycle strobe at Phi0 rise.
- phi0_negedge_i  in  1  one-cycle strobe at Phi0 fall.
- phi1_posedge_i  in  1  one-cycle strobe at Phi1 rise.
- addr_i  in  16  address latched during Phi1.
- rw_n_i  in  1  latched R/W; 1 = read.
- dma_n_i  in  1  bus DMA active when low; suppresses drive.
- rd_req_o  out  1  read request to card logic.
- rd_sel_o  out  2  0 = DEVSEL, 1 = IOSEL, 2 = IOSTROBE.
- rd_addr_o  out  11  offset: addr[3:0], addr[7:0] or addr[10:0] by select, zero-extended.
- rd_ack_i  in  1  one-cycle ack; rd_data_i valid with it.
- rd_data_i  in  8  response byte.
- a2_d_o  out  8  data to bus transceiver.
- a2_d_oe_o  out  1  transceiver drive enable.
- expansion_owned_o  out  1  card owns $C800–$CFFF.
- timeout_o  out  1  one-cycle pulse on missed ack deadline.

## Operation
- Reset values: rd_req_o=0, rd_sel_o=0, rd_addr_o=0, a2_d_o=0, a2_d_oe_o=0, expansion_owned_o=0, timeout_o=0, state IDLE, cycle counter 0.
- Counter cnt: cleared on phi0_posedge_i; otherwise increments and saturates at 63.
- Decode happens on phi0_posedge_i. A cycle is a hit when rw_n_i=1, timing_lock_i=1, dma_n_i=1 and the address is in DEVSEL, IOSEL or IOSTROBE space.
- IDLE: on a hit, go to REQ. Register rd_sel_o and rd_addr_o, and assert rd_req_o the next cycle.
- REQ: hold rd_req_o until rd_ack_i.
  - On ack, capture rd_data_i into a2_d_o, drop rd_req_o, go to WAIT.
  - If cnt reaches DRIVE_START_COUNT with no ack, drop rd_req_o, pulse timeout_o, go to IDLE. The bus is not driven.
  - Ack and deadline in the same cycle: the ack wins.
- WAIT: when cnt == DRIVE_START_COUNT, set a2_d_oe_o=1 and go to DRIVE. An ack arriving before the deadline still waits for it.
- DRIVE: on phi0_negedge_i go to HOLD with a HOLD_COUNT down-counter. If phi1_posedge_i arrives first (a missed negedge), go to HOLD the same way.
- HOLD: after HOLD_COUNT cycles, clear a2_d_oe_o and go to IDLE. A phi0_posedge_i during HOLD clears oe immediately and is decoded as a new cycle.
- If timing_lock_i or dma_n_i falls in any non-IDLE state:
  - a2_d_oe_o clears the next cycle.
  - rd_req_o drops.
  - The state returns to IDLE.
- Synchronous reset mid-transaction returns every output to its reset value on the next edge.
- Writes are never driven. They do update expansion ownership.

## Timing
- Phi0 lasts about 26 cycles. With default parameters, drive covers cnt 8 through phi0_negedge+2, i.e. about 148 ns after Phi0 rise to about 37 ns past Phi0 fall.
- Request latency: rd_req_o goes high 1 cycle after phi0_posedge_i. Card logic therefore has DRIVE_START_COUNT−1 cycles to acknowledge.
- a2_d_o is stable for the whole time a2_d_oe_o is high. It changes only on an ack in REQ.

## Configuration
- APPLE_BUS_EXPROM_EN defined:
  - Any access (read or write) to page $Cn00 sets expansion_owned_o.
  - Any access to $CFFF clears it. A read of $CFFF is not driven.
  - A read of $C800–$CFFE is an IOSTROBE hit while owned.
  - An IOSEL access and a $CFFF access in sequence are processed in bus order.
- Undefined: no IOSTROBE decode, expansion_owned_o tied to 0, and only DEVSEL and IOSEL respond.

## Test plan
- SLOT=4, read $C0C3, ack with $5A at cnt 3 → rd_sel_o=0, rd_addr_o=3; a2_d_oe_o high from cnt 8 until phi0_negedge+2; a2_d_o=$5A.
- Read $C4A7, never ack → timeout_o pulses at cnt 8; a2_d_oe_o stays 0.
- Write $C0C0 → no rd_req_o and no drive.
- With APPLE_BUS_EXPROM_EN: read $C400, then read $C812 → second read gives rd_sel_o=2, rd_addr_o=$012. Then read $CFFF → expansion_owned_o=0, no drive; a following read of $C812 is ignored.
- Read $C0C3 with dma_n_i pulled low at cnt 10 → a2_d_oe_o drops at cnt 11; state returns to IDLE.
- Assert system_reset_i during DRIVE → all outputs 0 on the next cycle; the next valid read is serviced normally.

Source files
------------

// File: rtl/apple_bus_responder.sv
// Apple II slot read responder: decodes DEVSEL/IOSEL (and IOSTROBE when built with
// APPLE_BUS_EXPROM_EN), fetches the byte from card logic and drives it inside Phi0.
module apple_bus_responder #(
  parameter int SLOT              = 4,
  parameter int DRIVE_START_COUNT = 8,
  parameter int HOLD_COUNT        = 2
) (
  input  logic        clk_logic_i,
  input  logic        system_reset_i,
  input  logic        timing_lock_i,
  input  logic        phi0_posedge_i,
  input  logic        phi0_negedge_i,
  input  logic        phi1_posedge_i,
  input  logic [15:0] addr_i,
  input  logic        rw_n_i,
  input  logic        dma_n_i,
  output logic        rd_req_o,
  output logic [1:0]  rd_sel_o,
  output logic [10:0] rd_addr_o,
  input  logic        rd_ack_i,
  input  logic [7:0]  rd_data_i,
  output logic [7:0]  a2_d_o,
  output logic        a2_d_oe_o,
  output logic        expansion_owned_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRIVE, HOLD} state_t;

  localparam logic [11:0] DEVSEL_BASE = 12'(12'hC08 + SLOT);
  localparam logic [7:0]  IOSEL_PAGE  = 8'(8'hC0 + SLOT);
  localparam logic [5:0]  DEADLINE    = 6'(DRIVE_START_COUNT - 1);
  localparam logic [3:0]  HOLD_RELOAD = 4'(HOLD_COUNT - 1);
  localparam logic [5:0]  CNT_MAX     = 6'd63;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  hold_q, hold_d;
  logic        owned_q, owned_d;
  logic        bus_ok, devsel_addr, iosel_addr, strobe_addr, hit, take;
  logic [1:0]  dec_sel;
  logic [10:0] dec_addr;
  logic        req_d, oe_d, timeout_d;
  logic [7:0]  data_d;
  logic [1:0]  sel_d;
  logic [10:0] addr_d;

  assign bus_ok      = timing_lock_i & dma_n_i;
  assign devsel_addr = (addr_i[15:4] == DEVSEL_BASE);
  assign iosel_addr  = (addr_i[15:8] == IOSEL_PAGE);

`ifdef APPLE_BUS_EXPROM_EN
  logic cfff_addr;
  assign cfff_addr   = (addr_i == 16'hCFFF);
  assign strobe_addr = owned_q && (addr_i[15:11] == 5'b11001) && !cfff_addr;

  // Ownership follows every bus access, reads and writes alike, in bus order.
  always_comb begin
    owned_d = owned_q;
    if (phi0_posedge_i && timing_lock_i) begin
      if (iosel_addr) begin
        owned_d = 1'b1;
      end else if (cfff_addr) begin
        owned_d = 1'b0;
      end
    end
  end
`else
  assign strobe_addr = 1'b0;
  assign owned_d     = 1'b0;
`endif

  assign hit  = phi0_posedge_i && rw_n_i && bus_ok && (devsel_addr || iosel_addr || strobe_addr);
  assign take = hit && ((state_q == IDLE) || (state_q == DRIVE) || (state_q == HOLD));

  always_comb begin
    dec_sel  = 2'd0;
    dec_addr = {7'd0, addr_i[3:0]};
    if (iosel_addr) begin
      dec_sel  = 2'd1;
      dec_addr = {3'd0, addr_i[7:0]};
    end else if (strobe_addr) begin
      dec_sel  = 2'd2;
      dec_addr = addr_i[10:0];
    end
  end

  // State register, Phi0 cycle counter and hold down-counter.
  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      owned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      owned_q <= owned_d;
    end
  end

  // Next state; an ack on the deadline cycle goes straight to DRIVE so oe still rises on time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (take) state_d = REQ;
      REQ: begin
        if (rd_ack_i) begin
          state_d = (cnt_q >= DEADLINE) ? DRIVE : WAIT;
        end else if (cnt_q >= DEADLINE) begin
          state_d = IDLE;
        end
      end
      WAIT:  if (cnt_q >= DEADLINE) state_d = DRIVE;
      DRIVE: begin
        if (phi0_posedge_i) begin
          state_d = take ? REQ : IDLE;
        end else if (phi0_negedge_i || phi1_posedge_i) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (phi0_posedge_i) begin
          state_d = take ? REQ : IDLE;
        end else if (hold_q == 4'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && !bus_ok) state_d = IDLE;
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    req_d     = (state_d == REQ);
    oe_d      = (state_d == DRIVE) || (state_d == HOLD);
    timeout_d = (state_q == REQ) && bus_ok && !rd_ack_i && (cnt_q >= DEADLINE);
    data_d    = a2_d_o;
    if ((state_q == REQ) && bus_ok && rd_ack_i) data_d = rd_data_i;
    sel_d  = rd_sel_o;
    addr_d = rd_addr_o;
    if (take) begin
      sel_d  = dec_sel;
      addr_d = dec_addr;
    end
    if (phi0_posedge_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 6'd1;
    end
    hold_d = hold_q;
    if ((state_d == HOLD) && (state_q != HOLD)) begin
      hold_d = HOLD_RELOAD;
    end else if ((state_q == HOLD) && (hold_q != 4'd0)) begin
      hold_d = hold_q - 4'd1;
    end
  end

  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      rd_req_o  <= 1'b0;
      rd_sel_o  <= 2'd0;
      rd_addr_o <= 11'd0;
      a2_d_o    <= 8'd0;
      a2_d_oe_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      rd_req_o  <= req_d;
      rd_sel_o  <= sel_d;
      rd_addr_o <= addr_d;
      a2_d_o    <= data_d;
      a2_d_oe_o <= oe_d;
      timeout_o <= timeout_d;
    end
  end

  assign expansion_owned_o = owned_q;

endmodule
